// File: rtl/persist_pkg.sv
// Shared encodings for the persistence pattern generator: pattern operators,
// brightness levels, palette selection and the 2-bit-per-channel colour type.
package persist_pkg;

    // Coordinate-arithmetic operator that forms the line pattern
    typedef enum logic [1:0] {
        MODE_XOR  = 2'b00,
        MODE_ADD  = 2'b01,
        MODE_SUB  = 2'b10,
        MODE_XNOR = 2'b11
    } mode_e;

    // Per-channel brightness levels for the 2-bit DAC
    localparam logic [1:0] LVL_OFF = 2'd0;
    localparam logic [1:0] LVL_LO  = 2'd1;
    localparam logic [1:0] LVL_MID = 2'd2;
    localparam logic [1:0] LVL_HI  = 2'd3;

    // Palette select: cyan head / yellow trail, or the red/blue swapped variant
    localparam logic PAL_CYAN = 1'b0;
    localparam logic PAL_SWAP = 1'b1;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb_t;

endpackage

// File: rtl/persist_frame_ctr.sv
// Frame counter with tick/step/pause arbitration and the per-frame shadow
// copies of the animation controls. Controls only change on frame_tick so a
// frame is always rendered with one consistent set of settings.
module persist_frame_ctr
    import persist_pkg::*;
#(
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_tick,
    input  logic             step,
    input  logic             pause,
    input  logic [1:0]       mode_in,
    input  logic             palette_in,
    input  logic [1:0]       speed_in,
    input  logic             dir_in,
    output logic [CNT_W-1:0] frame_no,
    output mode_e            mode_s,
    output logic             palette_s,
    output logic             dir_s
);

    logic [CNT_W-1:0] frame_q, frame_d;
    logic [CNT_W-1:0] inc;
    mode_e            mode_q, mode_d;
    logic             palette_q, palette_d;
    logic [1:0]       speed_q, speed_d;
    logic             dir_q, dir_d;

    // Next counter value (uses the pre-tick speed/direction) and shadow capture
    always_comb begin
        inc = '0;
        if (!pause && frame_tick) begin
            inc = CNT_W'({1'b0, speed_q}) + CNT_W'(1);
        end else if (pause && step) begin
            inc = CNT_W'(1);
        end
        frame_d   = dir_q ? (frame_q - inc) : (frame_q + inc);
        mode_d    = mode_q;
        palette_d = palette_q;
        speed_d   = speed_q;
        dir_d     = dir_q;
        if (frame_tick) begin
            mode_d    = mode_e'(mode_in);
            palette_d = palette_in;
            speed_d   = speed_in;
            dir_d     = dir_in;
        end
    end

    // Counter and shadow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q   <= '0;
            mode_q    <= MODE_XOR;
            palette_q <= PAL_CYAN;
            speed_q   <= 2'd0;
            dir_q     <= 1'b0;
        end else begin
            frame_q   <= frame_d;
            mode_q    <= mode_d;
            palette_q <= palette_d;
            speed_q   <= speed_d;
            dir_q     <= dir_d;
        end
    end

    assign frame_no  = frame_q;
    assign mode_s    = mode_q;
    assign palette_s = palette_q;
    assign dir_s     = dir_q;

endmodule

// File: rtl/persist_pattern_gen.sv
// Moving line-pattern renderer with an N_LAG-frame phosphor trail. Each pixel
// is compared against the pattern of the current frame and the N_LAG-1
// previous ones; the youngest matching frame decides brightness and tint.
module persist_pattern_gen
    import persist_pkg::*;
#(
    parameter int N_LAG  = 15,
    parameter int CNT_W  = 9,
    parameter int ACT_W  = 512,
    parameter int ACT_H  = 480,
    parameter int L3_END = 3,
    parameter int L2_END = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9:0]       hpos,
    input  logic [9:0]       vpos,
    input  logic             display_on,
    input  logic             frame_tick,
    input  logic [1:0]       mode,
    input  logic             palette,
    input  logic [1:0]       speed,
    input  logic             dir,
    input  logic             pause,
    input  logic             step,
    output logic [1:0]       r,
    output logic [1:0]       g,
    output logic [1:0]       b,
    output logic [CNT_W-1:0] frame_no
);

    localparam logic [10:0] ACT_W_L = 11'(ACT_W);
    localparam logic [10:0] ACT_H_L = 11'(ACT_H);

    mode_e            mode_s;
    logic             palette_s;
    logic             dir_s;
    logic [CNT_W-1:0] frame_w;

    persist_frame_ctr #(.CNT_W(CNT_W)) u_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .step       (step),
        .pause      (pause),
        .mode_in    (mode),
        .palette_in (palette),
        .speed_in   (speed),
        .dir_in     (dir),
        .frame_no   (frame_w),
        .mode_s     (mode_s),
        .palette_s  (palette_s),
        .dir_s      (dir_s)
    );

    assign frame_no = frame_w;

    function automatic logic [CNT_W-1:0] pattern_val(input mode_e m,
                                                     input logic [CNT_W-1:0] v,
                                                     input logic [CNT_W-1:0] f);
        case (m)
            MODE_XOR:  pattern_val = v ^ f;
            MODE_ADD:  pattern_val = v + f;
            MODE_SUB:  pattern_val = v - f;
            default:   pattern_val = ~(v ^ f);
        endcase
    endfunction

    function automatic logic [1:0] level_for(input logic [5:0] idx);
        if (int'(idx) < L3_END)      level_for = LVL_HI;
        else if (int'(idx) < L2_END) level_for = LVL_MID;
        else                         level_for = LVL_LO;
    endfunction

    logic [CNT_W-1:0] v, h, f;
    logic             hit;
    logic [5:0]       hit_idx;
    logic             in_area;
    logic [1:0]       lvl;
    rgb_t             pix;
    logic [1:0]       r_d, g_d, b_d;
    logic [1:0]       r_q, g_q, b_q;

    // Priority match over trail frames (scan high to low so lowest index wins) and colour mapping
    always_comb begin
        v       = vpos[CNT_W-1:0];
        h       = hpos[CNT_W-1:0];
        f       = '0;
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_LAG - 1; i >= 0; i--) begin
            f = dir_s ? (frame_w + CNT_W'(i)) : (frame_w - CNT_W'(i));
            if (h == pattern_val(mode_s, v, f)) begin
                hit     = 1'b1;
                hit_idx = 6'(i);
            end
        end
        in_area = display_on && ({1'b0, hpos} < ACT_W_L) && ({1'b0, vpos} < ACT_H_L);
        lvl     = (hit_idx == 6'd0) ? LVL_HI : level_for(hit_idx);
        pix     = '{r: LVL_OFF, g: LVL_OFF, b: LVL_OFF};
        if (hit && in_area) begin
            if (hit_idx == 6'd0) pix = '{r: LVL_OFF, g: lvl, b: lvl};
            else                 pix = '{r: lvl, g: lvl, b: LVL_OFF};
        end
        r_d = pix.r;
        g_d = pix.g;
        b_d = pix.b;
        if (palette_s == PAL_SWAP) begin
            r_d = pix.b;
            b_d = pix.r;
        end
    end

    // Registered colour outputs, one cycle behind the pixel coordinates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= LVL_OFF;
            g_q <= LVL_OFF;
            b_q <= LVL_OFF;
        end else begin
            r_q <= r_d;
            g_q <= g_d;
            b_q <= b_d;
        end
    end

    assign r = r_q;
    assign g = g_q;
    assign b = b_q;

endmodule

// File: tb/tb_persist_pattern_gen.sv
// Directed bench for persist_pattern_gen with hand-computed expected colours
// and frame counts.
module tb_persist_pattern_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] hpos, vpos;
    logic       display_on, frame_tick, palette, dir, pause, step;
    logic [1:0] mode, speed;
    logic [1:0] r, g, b;
    logic [8:0] frame_no;

    int checks = 0;
    int errors = 0;

    persist_pattern_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hpos       (hpos),
        .vpos       (vpos),
        .display_on (display_on),
        .frame_tick (frame_tick),
        .mode       (mode),
        .palette    (palette),
        .speed      (speed),
        .dir        (dir),
        .pause      (pause),
        .step       (step),
        .r          (r),
        .g          (g),
        .b          (b),
        .frame_no   (frame_no)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    // present a pixel and check the registered colour one cycle later
    task automatic pix(input string tag, input int x, input int y,
                       input logic [1:0] er, input logic [1:0] eg, input logic [1:0] eb);
        hpos = 10'(x);
        vpos = 10'(y);
        cyc();
        check_eq(tag, {26'd0, r, g, b}, {26'd0, er, eg, eb});
    endtask

    initial begin
        rst_n = 1'b0; hpos = '0; vpos = '0; display_on = 1'b1; frame_tick = 1'b0;
        mode = 2'b00; palette = 1'b0; speed = 2'd0; dir = 1'b0; pause = 1'b0; step = 1'b0;
        repeat (2) cyc();
        check_eq("reset_frame", {23'd0, frame_no}, 32'd0);
        check_eq("reset_rgb", {26'd0, r, g, b}, 32'd0);
        rst_n = 1'b1;
        cyc();

        // three ticks at speed 0, XOR, cyan palette, counting up
        repeat (3) begin pulse_tick(); cyc(); end
        check_eq("three_ticks", {23'd0, frame_no}, 32'd3);
        pix("head_h3", 3, 0, 2'd0, 2'd3, 2'd3);
        pix("trail_i1", 2, 0, 2'd3, 2'd3, 2'd0);
        pix("trail_i5_mid", 510, 0, 2'd2, 2'd2, 2'd0);
        pix("trail_i8_lo", 507, 0, 2'd1, 2'd1, 2'd0);
        pix("no_hit", 100, 0, 2'd0, 2'd0, 2'd0);

        // mode change mid-frame must not show until the next tick
        mode = 2'b01;
        pix("shadow_xor_kept", 2, 1, 2'd0, 2'd3, 2'd3);
        pulse_tick();
        check_eq("tick_to_4", {23'd0, frame_no}, 32'd4);
        pix("add_head", 8, 4, 2'd0, 2'd3, 2'd3);

        // pause / step
        pause = 1'b1;
        repeat (5) begin pulse_tick(); cyc(); end
        check_eq("paused_ticks", {23'd0, frame_no}, 32'd4);
        step = 1'b1; cyc(); step = 1'b0;
        check_eq("paused_step", {23'd0, frame_no}, 32'd5);
        pause = 1'b0;
        step = 1'b1; cyc(); step = 1'b0;
        check_eq("unpaused_step_only", {23'd0, frame_no}, 32'd5);
        speed = 2'd2;
        pulse_tick();
        check_eq("speed_pre_tick", {23'd0, frame_no}, 32'd6);
        step = 1'b1; frame_tick = 1'b1; cyc(); step = 1'b0; frame_tick = 1'b0;
        check_eq("tick_and_step", {23'd0, frame_no}, 32'd9);

        // bounds at frame 9, ADD: head at hpos = vpos + 9
        pix("match_in_area", 8, 10, 2'd1, 2'd1, 2'd0);
        pix("match_hpos_520", 520, 10, 2'd0, 2'd0, 2'd0);
        pix("match_vpos_490", 499, 490, 2'd0, 2'd0, 2'd0);
        display_on = 1'b0;
        pix("display_off", 9, 0, 2'd0, 2'd0, 2'd0);
        display_on = 1'b1;
        pix("display_on_head", 9, 0, 2'd0, 2'd3, 2'd3);

        // palette swap
        palette = 1'b1;
        pulse_tick();
        check_eq("tick_speed3", {23'd0, frame_no}, 32'd12);
        pix("pal_swap_head", 12, 0, 2'd3, 2'd3, 2'd0);
        pix("pal_swap_trail", 11, 0, 2'd0, 2'd3, 2'd3);

        // count down: first tick still uses old dir/speed
        palette = 1'b0; mode = 2'b00; speed = 2'd0; dir = 1'b1;
        pulse_tick();
        check_eq("dir_pre_tick", {23'd0, frame_no}, 32'd15);
        pulse_tick();
        check_eq("dir_down", {23'd0, frame_no}, 32'd14);
        pix("down_head", 14, 0, 2'd0, 2'd3, 2'd3);
        pix("down_trail_i1", 15, 0, 2'd3, 2'd3, 2'd0);
        repeat (14) pulse_tick();
        check_eq("down_to_0", {23'd0, frame_no}, 32'd0);
        pulse_tick();
        check_eq("wrap_0_to_511", {23'd0, frame_no}, 32'd511);

        // back up through the wrap 511 -> 0
        dir = 1'b0;
        pulse_tick();
        check_eq("last_down", {23'd0, frame_no}, 32'd510);
        pulse_tick();
        check_eq("up_511", {23'd0, frame_no}, 32'd511);
        pulse_tick();
        check_eq("wrap_511_to_0", {23'd0, frame_no}, 32'd0);
        pix("wrap_trail_511", 511, 0, 2'd3, 2'd3, 2'd0);
        pix("wrap_head_0", 0, 0, 2'd0, 2'd3, 2'd3);

        // asynchronous reset mid-line with the head pixel being drawn
        repeat (4) pulse_tick();
        pix("pre_reset_head", 4, 0, 2'd0, 2'd3, 2'd3);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_rgb", {26'd0, r, g, b}, 32'd0);
        check_eq("async_rst_frame", {23'd0, frame_no}, 32'd0);
        display_on = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        check_eq("post_release_rgb", {26'd0, r, g, b}, 32'd0);
        check_eq("post_release_frame", {23'd0, frame_no}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/persist_pattern_gen.md
Name: persist_pattern_gen

Overview:
Parametrised successor to the single-pattern VGA persistence renderer. It computes a moving coordinate-arithmetic line pattern with an N_LAG-frame phosphor-persistence trail and drives 2-bit R/G/B.
- Pattern operator, trail palette, animation speed, direction and pause/single-step are runtime-selectable.
- The frame counter is clocked on clk through a frame_tick strobe, not on the sync edge.
- Sits between hvsync_generator (hpos/vpos/display_on) and the Tiny VGA Pmod output mapping in the top level.

Parameters:
- N_LAG, 15, number of trail frames including the head (1..32).
- CNT_W, 9, frame-counter and compare width in bits; compare uses hpos/vpos[CNT_W-1:0].
- ACT_W, 512, horizontal pixels rendered; hpos >= ACT_W is black.
- ACT_H, 480, vertical lines rendered; vpos >= ACT_H is black.
- L3_END, 3, trail index i < L3_END uses level 3.
- L2_END, 7, L3_END <= i < L2_END uses level 2; i >= L2_END uses level 1.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- hpos  in  10  current X from hvsync_generator.
- vpos  in  10  current Y from hvsync_generator.
- display_on  in  1  visible-area flag.
- frame_tick  in  1  one-clk strobe, once per frame, asserted during vertical blanking.
- mode  in  2  pattern operator: 00 XOR, 01 ADD, 10 SUB, 11 XNOR.
- palette  in  1  0 = cyan head / yellow trail; 1 = red/blue channels swapped.
- speed  in  2  counter increment per tick = speed+1.
- dir  in  1  0 = count up, 1 = count down.
- pause  in  1  1 = ignore frame_tick.
- step  in  1  one-clk strobe; advances the counter once while paused.
- r  out  2  red level.
- g  out  2  green level.
- b  out  2  blue level.
- frame_no  out  CNT_W  current frame counter value.

Behaviour:
- Reset (async assert, release synchronous to clk): frame_no=0, r=g=b=0, shadow mode=00, palette=0, speed=0, dir=0.
- Shadow registers: mode/palette/speed/dir are sampled only on cycles where frame_tick=1, regardless of pause. Mid-frame input changes have no visible effect until the next tick.
- Counter update per cycle:
  - pause=0 and frame_tick=1: frame_no += inc when dir=0, or -= inc when dir=1, where inc = speed_shadow+1 using the pre-tick shadow value.
  - pause=1 and step=1: advance by exactly 1 in the shadow direction.
  - pause=0 and step=1 without frame_tick: no change.
  - frame_tick and step together while unpaused: one advance only (tick rule).
  - Arithmetic is modulo 2^CNT_W; 511+1 -> 0 and 0-1 -> 511 at CNT_W=9.
- Trail frame values:
  - f_i = frame_no - i when dir=0, or frame_no + i when dir=1, mod 2^CNT_W, for i = 0..N_LAG-1.
- Pattern value P_i, with v = vpos[CNT_W-1:0]:
  - XOR: v ^ f_i.
  - ADD: v + f_i.
  - SUB: v - f_i.
  - XNOR: ~(v ^ f_i).
- Match: hit_i = (hpos[CNT_W-1:0] == P_i). If several i hit, the lowest i wins (priority encoder, not OR).
- Level and tint for the winning index:
  - i=0: level 3, tint 0.
  - i >= 1: level from L3_END/L2_END, tint 1.
- Colour for palette 0:
  - tint 0 (head): r=0, g=level, b=level.
  - tint 1 (trail): r=level, g=level, b=0.
  - palette 1 swaps r and b.
- Blanking: r=g=b=0 when there is no hit, display_on=0, hpos >= ACT_W, or vpos >= ACT_H.
- Latency: r/g/b are registered; the output on cycle n+1 reflects hpos/vpos on cycle n and the frame_no value present on cycle n.
- Reset mid-frame: outputs go to 0 immediately (async) and stay 0 through the first post-release cycle.

Decomposition:
- Shared package persist_pkg holds:
  - mode encodings MODE_XOR/ADD/SUB/XNOR;
  - level constants LVL_OFF/LO/MID/HI;
  - palette encodings PAL_CYAN/PAL_SWAP.
- One sub-module, persist_frame_ctr, contains the counter, the pause/step/tick arbitration and the shadow registers, and outputs frame_no plus the shadowed controls.

Test Plan:
- Reset: rst_n=0 mid-line with pattern active -> r=g=b=0 and frame_no=0 immediately; after release with display_on=0 -> outputs stay 0.
- Head and trail: 3 ticks with speed=0, mode=XOR, palette=0, dir=0 -> frame_no=3.
  - vpos=0, hpos=3 -> next cycle r=0, g=3, b=3.
  - vpos=0, hpos=2 -> r=3, g=3, b=0.
  - vpos=0, hpos=12 (i=... no match, frame 3^0 lags give 3..-11) check hpos = 0^(3-5)=510 -> r=2, g=2, b=0.
- Wrap: preload to frame_no=511 via ticks, then one tick -> frame_no=0. At vpos=0, hpos=511, mode=XOR (i=1) -> r=3, g=3, b=0.
- Pause/step: pause=1, 5 ticks -> frame_no unchanged. One step -> +1. pause=0 with a tick and step in the same cycle and speed=2 -> +3 only.
- Shadowing: set mode=ADD mid-frame -> output still follows XOR until the next tick. After the tick, vpos=4, frame_no=F, hpos=(4+F) mod 512 -> head colour.
- Bounds: a match at hpos=520 with vpos=10 -> black. A match at vpos=490 -> black. display_on=0 on a matching pixel -> black. palette=1 on the head pixel -> r=3, g=3, b=0.
